imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Program loader that writes the instruction memory, the write-side counterpart to the read-only instruction ROM.
- Accepts a byte stream on a valid/ready handshake.
- Assembles little-endian 32-bit words and issues one word-aligned write per word, starting at address 0.
- Holds the core in reset until the whole image has been written.
- Sits between the host byte source (UART receiver or test bench) and a writable instruction memory port.

Parameters:
DEPTH, 64, instruction memory capacity in 32-bit words.
AW, $clog2(DEPTH), word-address width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse: begin a load of len_words words.
abort  input  1  one-cycle pulse: cancel the load in progress.
len_words  input  AW+1  number of words to load; sampled on start.
byte_valid  input  1  byte_data is valid.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts the byte this cycle.
mem_we  output  1  instruction memory write enable, one cycle per word.
mem_addr  output  32  byte address of the write, always word-aligned (bits [1:0] = 0).
mem_wdata  output  32  word to write.
cpu_reset  output  1  active-high core reset request.
busy  output  1  a load is in progress.
done  output  1  sticky: last load completed.
error  output  1  sticky: last start had an illegal length.

Behaviour:
- Reset (reset_n low, takes effect immediately, independent of clk):
  - state=IDLE, byte_cnt=0, word_idx=0.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, busy=0, done=0, error=0.
- Outputs are driven from registers or from the decoded state; there is no combinational path from byte_valid to byte_ready.
- States and transitions:
  - IDLE: byte_ready=0.
    - start with len_words==0 or len_words>DEPTH -> ERR.
    - start with a legal length -> latch len, word_idx=0, byte_cnt=0, -> RECV.
  - RECV: byte_ready=1, busy=1.
    - Transfer occurs when byte_valid && byte_ready.
    - Byte k of the word (k=byte_cnt, 0..3) lands in bits [8k+7:8k].
    - The transfer with byte_cnt==3 moves to WRITE and resets byte_cnt.
    - Gaps in byte_valid are allowed and have no effect.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr={word_idx,2'b00} zero-extended to 32 bits, mem_wdata=assembled word, byte_ready=0, busy=1.
    - Then word_idx++.
    - If word_idx+1==len -> DONE, else -> RECV.
  - DONE: done=1, cpu_reset=0, busy=0.
  - ERR: error=1, cpu_reset=1, no memory writes.
- cpu_reset=1 in every state except DONE.
- Latency: the 4th byte is accepted at edge N; mem_we is high in cycle N+1; done goes high at the edge ending the final WRITE cycle.
- start handling:
  - In IDLE, DONE or ERR, start clears done and error and is evaluated as in IDLE.
  - In RECV or WRITE, start is ignored.
- abort:
  - In RECV: -> IDLE next edge, the partial word is discarded, no write is issued, done=0, error=0.
  - In WRITE: the write in that cycle completes, then -> IDLE.
  - In any other state abort has no effect.
  - abort and start in the same cycle: abort wins, start is ignored.
- No wrap-around:
  - Legal lengths never exceed DEPTH.
  - The highest write address is (DEPTH-1)*4, i.e. 0xFC for the default.
- Words already written persist in memory after an abort or reset; the loader never clears memory.
- reset_n asserted mid-load: outputs return to reset values immediately; any in-flight write is dropped.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, RECV, WRITE, DONE, ERR), BYTES_PER_WORD=4, the word-alignment shift of 2.
- One sub-module, word_assembler:
  - Holds the byte counter and the 32-bit shift/insert register.
  - Outputs word_full and word.
  - Has a clear input, driven by abort and start.
- The top level keeps the FSM, word_idx and the length check.

Test Plan:
1. Reset check: reset_n low, then high with no start -> cpu_reset=1, mem_we=0, byte_ready=0, done=0, error=0.
2. Load of len_words=2, bytes 93 03 40 00 13 0E 10 00 -> two writes: addr 0x00 data 0x00400393, addr 0x04 data 0x00100E13. Then done=1, cpu_reset=0, and exactly 2 mem_we pulses.
3. Same image with byte_valid randomly deasserted, 1-5 idle cycles between bytes -> identical writes and ordering; byte_ready low in every WRITE cycle.
4. start with len_words=0, then again with 65 -> error=1, cpu_reset=1, no mem_we. A following legal start clears error.
5. abort after 2 bytes of word 0 -> no mem_we, return to IDLE. A new load of 1 word (bytes 13 F3 43 00) writes addr 0x00 data 0x0043F313.
6. Full load of 64 words -> last write at addr 0xFC, then done. Also: reset_n pulsed low during a WRITE cycle -> mem_we drops immediately, all outputs at reset values.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and word geometry.
package imem_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_full flags the byte completing a word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);

    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;

    // Each lane only loads when the counter points at it, so stale lanes are
    // always overwritten before the word is next presented.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word_d[8*gi +: 8] = clear ? 8'h00 :
                (byte_en && (byte_cnt_q == BCNT_W'(gi))) ? byte_in : word_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            byte_cnt_d = '0;
        end else if (byte_en) begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    assign word_full = byte_en && !clear && (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    assign word      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory one word per write, holding the core in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   len_words,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] word_idx_q, word_idx_d;
    logic [AW:0]   len_q, len_d;

    logic          in_recv, in_write, in_done, in_err, in_rest;
    logic          len_legal, start_ok, xfer, asm_clear, word_full;
    logic [AW:0]   idx_plus1;
    logic [31:0]   word;

    assign in_recv   = (state_q == ST_RECV);
    assign in_write  = (state_q == ST_WRITE);
    assign in_done   = (state_q == ST_DONE);
    assign in_err    = (state_q == ST_ERR);
    assign in_rest   = !in_recv && !in_write;

    assign len_legal = (len_words != '0) && (len_words <= (AW+1)'(DEPTH));
    // Abort beats start; start is only honoured while no load is running.
    assign start_ok  = start && !abort && in_rest;
    assign xfer      = byte_valid && in_recv;
    assign asm_clear = start_ok || (abort && !in_rest);
    assign idx_plus1 = {1'b0, word_idx_q} + (AW+1)'(1);

    word_assembler u_asm (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (asm_clear),
        .byte_en   (xfer),
        .byte_in   (byte_data),
        .word_full (word_full),
        .word      (word)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        case (state_q)
            ST_RECV: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (word_full) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + AW'(1);
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (idx_plus1 == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: begin
                if (start_ok) begin
                    if (len_legal) begin
                        len_d      = len_words;
                        word_idx_d = '0;
                        state_d    = ST_RECV;
                    end else begin
                        state_d    = ST_ERR;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
        end
    end

    // Everything below decodes from state, so reset clears the outputs at once.
    assign byte_ready = in_recv;
    assign mem_we     = in_write;
    assign mem_addr   = in_write ? (32'(word_idx_q) << WORD_SHIFT) : 32'h0;
    assign mem_wdata  = in_write ? word : 32'h0;
    assign cpu_reset  = !in_done;
    assign busy       = in_recv || in_write;
    assign done       = in_done;
    assign error      = in_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte images in, expected word writes derived from the image.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  len_words = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, cpu_reset, busy, done, error;
    logic [31:0] mem_addr, mem_wdata;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .len_words  (len_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  img[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: word i of the image is bytes 4i..4i+3 little-endian, written at byte address 4i.
    task automatic expect_image();
        for (int i = 0; i < img.size() / 4; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_data_q.push_back({img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
        end
    endtask

    always @(negedge clk) begin
        chk("cpu_reset_vs_done", {31'h0, cpu_reset}, {31'h0, !done});
        chk("busy_excl", {31'h0, busy && (done || error)}, 32'h0);
        if (mem_we) begin
            chk("we_ready_low", {31'h0, byte_ready}, 32'h0);
            chk("write_expected", {31'h0, exp_addr_q.size() != 0}, 32'h1);
            if (exp_addr_q.size() != 0) begin
                chk("wr_addr", mem_addr, exp_addr_q.pop_front());
                chk("wr_data", mem_wdata, exp_data_q.pop_front());
            end
            $display("write addr=%h data=%h", mem_addr, mem_wdata);
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("byte_accept_timeout", {31'h0, byte_ready}, 32'h1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_image(input int max_gap);
        for (int i = 0; i < img.size(); i++) begin
            if (max_gap > 0) repeat ($urandom_range(1, max_gap)) @(negedge clk);
            send_byte(img[i]);
        end
    endtask

    task automatic pulse_start(input int len);
        start     = 1'b1;
        len_words = 7'(len);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'h0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("t1_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        chk("t1_mem_we", {31'h0, mem_we}, 32'h0);
        chk("t1_byte_ready", {31'h0, byte_ready}, 32'h0);
        chk("t1_done", {31'h0, done}, 32'h0);
        chk("t1_error", {31'h0, error}, 32'h0);

        img = '{8'h93, 8'h03, 8'h40, 8'h00, 8'h13, 8'h0E, 8'h10, 8'h00};
        expect_image();
        base = wr_addr_log.size();
        pulse_start(2);
        send_image(0);
        chk("t2_we_latency", {31'h0, mem_we}, 32'h1);
        chk("t2_done_not_yet", {31'h0, done}, 32'h0);
        @(negedge clk);
        chk("t2_done", {31'h0, done}, 32'h1);
        chk("t2_cpu_reset", {31'h0, cpu_reset}, 32'h0);
        chk("t2_writes", 32'(wr_addr_log.size() - base), 32'd2);
        chk("t2_pending", 32'(exp_addr_q.size()), 32'd0);
        chk("t2_w0_addr", wr_addr_log[base], 32'h00);
        chk("t2_w0_data", wr_data_log[base], 32'h00400393);
        chk("t2_w1_addr", wr_addr_log[base+1], 32'h04);
        chk("t2_w1_data", wr_data_log[base+1], 32'h00100E13);

        expect_image();
        base = wr_addr_log.size();
        pulse_start(2);
        chk("t3_busy", {31'h0, busy}, 32'h1);
        chk("t3_done_cleared", {31'h0, done}, 32'h0);
        send_image(5);
        wait_done("t3_done");
        chk("t3_writes", 32'(wr_addr_log.size() - base), 32'd2);
        chk("t3_w1_data", wr_data_log[base+1], 32'h00100E13);

        base = wr_addr_log.size();
        pulse_start(0);
        chk("t4_err_len0", {31'h0, error}, 32'h1);
        chk("t4_done_cleared", {31'h0, done}, 32'h0);
        chk("t4_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        pulse_start(65);
        chk("t4_err_len65", {31'h0, error}, 32'h1);
        repeat (3) @(negedge clk);
        chk("t4_no_writes", 32'(wr_addr_log.size() - base), 32'd0);
        pulse_start(1);
        chk("t4_err_cleared", {31'h0, error}, 32'h0);
        chk("t4_busy", {31'h0, busy}, 32'h1);

        send_byte(8'h11);
        send_byte(8'h22);
        pulse_abort();
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_byte_ready", {31'h0, byte_ready}, 32'h0);
        chk("t5_done", {31'h0, done}, 32'h0);
        chk("t5_error", {31'h0, error}, 32'h0);
        repeat (3) @(negedge clk);
        chk("t5_no_writes", 32'(wr_addr_log.size() - base), 32'd0);
        img = '{8'h13, 8'hF3, 8'h43, 8'h00};
        expect_image();
        pulse_start(1);
        send_image(0);
        wait_done("t5_done_after_reload");
        chk("t5_w_addr", wr_addr_log[wr_addr_log.size()-1], 32'h00);
        chk("t5_w_data", wr_data_log[wr_data_log.size()-1], 32'h0043F313);

        img.delete();
        for (int i = 0; i < DEPTH; i++)
            for (int k = 0; k < 4; k++)
                img.push_back(8'(i * 7 + k * 61 + 1));
        expect_image();
        base = wr_addr_log.size();
        pulse_start(DEPTH);
        send_image(0);
        wait_done("t6_done");
        chk("t6_writes", 32'(wr_addr_log.size() - base), 32'd64);
        chk("t6_last_addr", wr_addr_log[wr_addr_log.size()-1], 32'hFC);
        chk("t6_last_data", wr_data_log[wr_data_log.size()-1], 32'h7134F7BA);
        chk("t6_pending", 32'(exp_addr_q.size()), 32'd0);

        img = '{8'h93, 8'h03, 8'h40, 8'h00, 8'h13, 8'h0E, 8'h10, 8'h00};
        expect_image();
        pulse_start(2);
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        chk("t6r_in_write", {31'h0, mem_we}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6r_mem_we", {31'h0, mem_we}, 32'h0);
        chk("t6r_mem_addr", mem_addr, 32'h0);
        chk("t6r_mem_wdata", mem_wdata, 32'h0);
        chk("t6r_byte_ready", {31'h0, byte_ready}, 32'h0);
        chk("t6r_busy", {31'h0, busy}, 32'h0);
        chk("t6r_done", {31'h0, done}, 32'h0);
        chk("t6r_error", {31'h0, error}, 32'h0);
        chk("t6r_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6r_idle_after", {31'h0, busy}, 32'h0);
        chk("t6r_cpu_reset_after", {31'h0, cpu_reset}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
